// File: rtl/ippro_run_ctrl_pkg.sv
// Shared types and constants for the IPPro run-control sequencer.
// The state encodings are fixed so they can be read directly in a waveform.
package ippro_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  localparam int DRAIN_CYC_DEF = 4;
  localparam int FLUSH_LEN     = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ippro_stall_counter.sv
// Saturating event counter with synchronous clear.
// Clear has priority over increment.
module ippro_stall_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: assign every always_comb output a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ippro_run_ctrl.sv
// Run-control sequencer for one IPPro core: program download, core reset,
// run until the last PC, pipeline drain, and FIFO-driven stall gating.
module ippro_run_ctrl
  import ippro_run_ctrl_pkg::*;
#(
  parameter int PC_W      = 10,
  parameter int INSTR_W   = 34,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF,
  parameter int CNT_W     = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               HOST_WE,
  input  logic [PC_W-1:0]    HOST_ADDR,
  input  logic [INSTR_W-1:0] HOST_DATA,
  input  logic               START,
  input  logic               ABORT,
  input  logic [PC_W-1:0]    PROG_LAST,
  input  logic [PC_W-1:0]    CORE_PC,
  input  logic               GET_REQ,
  input  logic               PUT_REQ,
  input  logic               IN_EMPTY,
  input  logic               OUT_FULL,
  output logic               IM_WE,
  output logic [PC_W-1:0]    IM_ADDR,
  output logic [INSTR_W-1:0] IM_DIN,
  output logic               CORE_RESET,
  output logic               ENABLE,
  output logic               ENABLE_PC,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR,
  output logic [CNT_W-1:0]   STALL_CNT
);

  localparam int PH_MAX = max_int(DRAIN_CYC, FLUSH_LEN);
  localparam int PH_W   = $clog2(PH_MAX + 1);

  state_e             state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [PC_W-1:0]    last_q, last_d;
  logic               err_q, err_d;
  logic               im_we_q, im_we_d;
  logic [PC_W-1:0]    im_addr_q;
  logic [INSTR_W-1:0] im_din_q;
  // Decoded state flags are registered so the datapath controls never glitch.
  logic               core_rst_q, core_rst_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               run_q, run_d;
  logic               drain_q, drain_d;

  logic stall;
  logic start_ok;

  assign stall    = (GET_REQ & IN_EMPTY) | (PUT_REQ & OUT_FULL);
  assign start_ok = (state_q == ST_IDLE) & START;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_FLUSH;
          phase_d = '0;
          last_d  = PROG_LAST;
        end
      end
      ST_FLUSH: begin
        if (phase_q == PH_W'(FLUSH_LEN - 1)) begin
          state_d = ST_RUN;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_RUN: begin
        if ((CORE_PC == last_q) && !stall) begin
          state_d = ST_DRAIN;
          phase_d = '0;
        end
      end
      ST_DRAIN: begin
        // Only unstalled cycles move instructions down the pipeline.
        if (!stall) begin
          if (phase_q == PH_W'(DRAIN_CYC - 1)) begin
            state_d = ST_FIN;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (ABORT && busy_q) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    core_rst_d = (state_d == ST_IDLE) || (state_d == ST_FLUSH);
    busy_d     = (state_d == ST_FLUSH) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d     = (state_d == ST_FIN);
    run_d      = (state_d == ST_RUN);
    drain_d    = (state_d == ST_DRAIN);
    im_we_d    = HOST_WE & ~busy_q;
    err_d      = start_ok ? 1'b0 : (err_q | (HOST_WE & busy_q));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      last_q     <= '0;
      err_q      <= 1'b0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_din_q   <= '0;
      core_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      run_q      <= 1'b0;
      drain_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      last_q     <= last_d;
      err_q      <= err_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= HOST_ADDR;
      im_din_q   <= HOST_DATA;
      core_rst_q <= core_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      run_q      <= run_d;
      drain_q    <= drain_d;
    end
  end

  ippro_stall_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (CLK),
    .rst  (RESET),
    .clr_i(start_ok),
    .inc_i(run_q & stall),
    .cnt_o(STALL_CNT)
  );

  assign IM_WE      = im_we_q;
  assign IM_ADDR    = im_addr_q;
  assign IM_DIN     = im_din_q;
  assign CORE_RESET = core_rst_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ERR        = err_q;
  // The only combinational path: stall inputs gate the enables in the same cycle.
  assign ENABLE     = (run_q | drain_q) & ~stall;
  assign ENABLE_PC  = run_q & ~stall;

endmodule

// File: tb/tb_ippro_run_ctrl.sv
// Directed bench for ippro_run_ctrl: host writes go through a scoreboard
// queue, run/stall/drain/abort behaviour is checked cycle by cycle.
module tb_ippro_run_ctrl;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 34;
  localparam int CNT_W   = 16;

  logic               CLK = 1'b0;
  logic               RESET = 1'b0;
  logic               HOST_WE = 1'b0;
  logic [PC_W-1:0]    HOST_ADDR = '0;
  logic [INSTR_W-1:0] HOST_DATA = '0;
  logic               START = 1'b0;
  logic               ABORT = 1'b0;
  logic [PC_W-1:0]    PROG_LAST = '0;
  logic [PC_W-1:0]    CORE_PC = '0;
  logic               GET_REQ = 1'b0;
  logic               PUT_REQ = 1'b0;
  logic               IN_EMPTY = 1'b0;
  logic               OUT_FULL = 1'b0;
  logic               IM_WE;
  logic [PC_W-1:0]    IM_ADDR;
  logic [INSTR_W-1:0] IM_DIN;
  logic               CORE_RESET;
  logic               ENABLE;
  logic               ENABLE_PC;
  logic               BUSY;
  logic               DONE;
  logic               ERR;
  logic [CNT_W-1:0]   STALL_CNT;

  int total = 0;
  int bad   = 0;
  logic [PC_W+INSTR_W-1:0] sb[$];

  ippro_run_ctrl dut (
    .CLK(CLK), .RESET(RESET),
    .HOST_WE(HOST_WE), .HOST_ADDR(HOST_ADDR), .HOST_DATA(HOST_DATA),
    .START(START), .ABORT(ABORT), .PROG_LAST(PROG_LAST), .CORE_PC(CORE_PC),
    .GET_REQ(GET_REQ), .PUT_REQ(PUT_REQ), .IN_EMPTY(IN_EMPTY), .OUT_FULL(OUT_FULL),
    .IM_WE(IM_WE), .IM_ADDR(IM_ADDR), .IM_DIN(IM_DIN),
    .CORE_RESET(CORE_RESET), .ENABLE(ENABLE), .ENABLE_PC(ENABLE_PC),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .STALL_CNT(STALL_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  // Scoreboard consumer: every registered write must match the oldest pending host write.
  always @(negedge CLK) begin
    if (!RESET && IM_WE) begin
      logic [PC_W+INSTR_W-1:0] e;
      check("im_we_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("im_addr", 64'(IM_ADDR), 64'(e[PC_W+INSTR_W-1:INSTR_W]));
        check("im_din", 64'(IM_DIN), 64'(e[INSTR_W-1:0]));
      end
    end
  end

  // Issues START and walks the two FLUSH cycles; returns in the first RUN cycle.
  task automatic start_run(input logic [PC_W-1:0] last);
    START = 1'b1;
    PROG_LAST = last;
    CORE_PC = '0;
    mid();
    check("start_idle_busy", 64'(BUSY), 64'd0);
    check("start_idle_en", 64'(ENABLE), 64'd0);
    nxt();
    START = 1'b0;
    mid();
    check("flush1_core_rst", 64'(CORE_RESET), 64'd1);
    check("flush1_busy", 64'(BUSY), 64'd1);
    check("flush1_en", 64'(ENABLE), 64'd0);
    nxt();
    mid();
    check("flush2_core_rst", 64'(CORE_RESET), 64'd1);
    check("flush2_en", 64'(ENABLE), 64'd0);
    nxt();
  endtask

  initial begin
    logic st;

    // Reset values, asynchronously applied before the first clock edge.
    #1 RESET = 1'b1;
    #2;
    check("rst_im_we", 64'(IM_WE), 64'd0);
    check("rst_im_addr", 64'(IM_ADDR), 64'd0);
    check("rst_im_din", 64'(IM_DIN), 64'd0);
    check("rst_core_rst", 64'(CORE_RESET), 64'd1);
    check("rst_en", 64'(ENABLE), 64'd0);
    check("rst_en_pc", 64'(ENABLE_PC), 64'd0);
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_done", 64'(DONE), 64'd0);
    check("rst_err", 64'(ERR), 64'd0);
    check("rst_stall_cnt", 64'(STALL_CNT), 64'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    nxt();

    // Program download in IDLE.
    for (int i = 0; i < 3; i++) begin
      HOST_WE = 1'b1;
      HOST_ADDR = PC_W'(i);
      HOST_DATA = INSTR_W'(64'h2_0000_00A5 + 64'(i) * 64'h1111);
      sb.push_back({HOST_ADDR, HOST_DATA});
      nxt();
    end
    HOST_WE = 1'b0;
    nxt();
    nxt();
    check("sb_drained_after_load", 64'(sb.size()), 64'd0);

    // Plain run to PC 5 with a host write attempted mid-run.
    start_run(PC_W'(5));
    for (int pc = 0; pc <= 5; pc++) begin
      CORE_PC = PC_W'(pc);
      HOST_WE = (pc == 2);
      HOST_ADDR = PC_W'(9);
      mid();
      check("run_en", 64'(ENABLE), 64'd1);
      check("run_en_pc", 64'(ENABLE_PC), 64'd1);
      check("run_core_rst", 64'(CORE_RESET), 64'd0);
      if (pc == 3) begin
        check("run_err_set", 64'(ERR), 64'd1);
        check("run_im_we_blocked", 64'(IM_WE), 64'd0);
      end
      nxt();
    end
    HOST_WE = 1'b0;
    for (int d = 0; d < 4; d++) begin
      mid();
      check("drain_en", 64'(ENABLE), 64'd1);
      check("drain_en_pc", 64'(ENABLE_PC), 64'd0);
      check("drain_done", 64'(DONE), 64'd0);
      check("drain_busy", 64'(BUSY), 64'd1);
      nxt();
    end
    mid();
    check("fin_done", 64'(DONE), 64'd1);
    check("fin_busy", 64'(BUSY), 64'd0);
    check("fin_en", 64'(ENABLE), 64'd0);
    nxt();
    mid();
    check("idle_done_low", 64'(DONE), 64'd0);
    check("idle_core_rst", 64'(CORE_RESET), 64'd1);
    check("idle_err_sticky", 64'(ERR), 64'd1);
    nxt();

    // RUN stalls on GET with empty input FIFO, DRAIN stalls on PUT with full output FIFO.
    start_run(PC_W'(3));
    CORE_PC = PC_W'(1);
    for (int s = 0; s < 5; s++) begin
      st = (s >= 1) && (s <= 3);
      GET_REQ = st;
      IN_EMPTY = st;
      mid();
      check("stall_en", 64'(ENABLE), 64'(!st));
      check("stall_en_pc", 64'(ENABLE_PC), 64'(!st));
      if (s == 0) check("err_cleared_on_start", 64'(ERR), 64'd0);
      nxt();
    end
    GET_REQ = 1'b0;
    IN_EMPTY = 1'b0;
    CORE_PC = PC_W'(3);
    mid();
    check("stall_cnt_3", 64'(STALL_CNT), 64'd3);
    nxt();
    for (int i = 0; i < 6; i++) begin
      st = (i == 1) || (i == 2);
      PUT_REQ = st;
      OUT_FULL = st;
      mid();
      check("sdrain_en", 64'(ENABLE), 64'(!st));
      check("sdrain_en_pc", 64'(ENABLE_PC), 64'd0);
      check("sdrain_done", 64'(DONE), 64'd0);
      nxt();
    end
    PUT_REQ = 1'b0;
    OUT_FULL = 1'b0;
    mid();
    check("sdrain_fin_done", 64'(DONE), 64'd1);
    check("sdrain_stall_cnt", 64'(STALL_CNT), 64'd3);
    nxt();

    // Abort in RUN at PC 2.
    start_run(PC_W'(7));
    for (int pc = 0; pc <= 2; pc++) begin
      CORE_PC = PC_W'(pc);
      ABORT = (pc == 2);
      mid();
      nxt();
    end
    ABORT = 1'b0;
    mid();
    check("abort_busy", 64'(BUSY), 64'd0);
    check("abort_core_rst", 64'(CORE_RESET), 64'd1);
    check("abort_en", 64'(ENABLE), 64'd0);
    check("abort_done", 64'(DONE), 64'd0);
    nxt();
    mid();
    check("abort_no_done", 64'(DONE), 64'd0);
    nxt();

    // Rerun with PROG_LAST=0: one instruction plus drain.
    start_run(PC_W'(0));
    mid();
    check("rerun_stall_cnt_clr", 64'(STALL_CNT), 64'd0);
    check("rerun_en", 64'(ENABLE), 64'd1);
    nxt();
    for (int d = 0; d < 4; d++) begin
      mid();
      check("rerun_drain_en_pc", 64'(ENABLE_PC), 64'd0);
      check("rerun_drain_done", 64'(DONE), 64'd0);
      nxt();
    end
    mid();
    check("rerun_done", 64'(DONE), 64'd1);
    nxt();

    // Stall counter saturation, then asynchronous reset mid-DRAIN.
    start_run(PC_W'(1));
    GET_REQ = 1'b1;
    IN_EMPTY = 1'b1;
    repeat (65538) nxt();
    mid();
    check("sat_stall_cnt", 64'(STALL_CNT), 64'hFFFF);
    check("sat_en", 64'(ENABLE), 64'd0);
    nxt();
    GET_REQ = 1'b0;
    IN_EMPTY = 1'b0;
    CORE_PC = PC_W'(1);
    mid();
    check("sat_hold", 64'(STALL_CNT), 64'hFFFF);
    nxt();
    mid();
    check("sat_drain_en", 64'(ENABLE), 64'd1);
    check("sat_drain_en_pc", 64'(ENABLE_PC), 64'd0);
    nxt();
    #2 RESET = 1'b1;
    #1;
    check("arst_im_we", 64'(IM_WE), 64'd0);
    check("arst_im_addr", 64'(IM_ADDR), 64'd0);
    check("arst_im_din", 64'(IM_DIN), 64'd0);
    check("arst_core_rst", 64'(CORE_RESET), 64'd1);
    check("arst_en", 64'(ENABLE), 64'd0);
    check("arst_en_pc", 64'(ENABLE_PC), 64'd0);
    check("arst_busy", 64'(BUSY), 64'd0);
    check("arst_done", 64'(DONE), 64'd0);
    check("arst_err", 64'(ERR), 64'd0);
    check("arst_stall_cnt", 64'(STALL_CNT), 64'd0);
    @(negedge CLK);
    RESET = 1'b0;
    nxt();
    mid();
    check("post_rst_busy", 64'(BUSY), 64'd0);
    check("post_rst_done", 64'(DONE), 64'd0);
    check("sb_empty_end", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
